// File: rtl/demosaic_pkg.sv
// Shared definitions for the demosaic pipeline stages.
//   WEIGHT_FRAC : fractional bits of the Q.20 interpolation weights
//   PIX_W       : output pixel width
//   acc_width() : accumulator width able to hold `taps` products of `prod_w` bits
//   acc_state_e : weighted-sum accumulator FSM states
package demosaic_pkg;

  localparam int WEIGHT_FRAC = 20;
  localparam int PIX_W       = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_e;

  function automatic int acc_width(input int prod_w, input int taps);
    return prod_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/demosaic_skid2.sv
// Generic 2-entry valid/ready skid buffer (small FIFO), shared by demosaic stages.
// The head entry drives m_data directly from a flop, so the output is stable
// while m_valid is high and m_ready is low.
//   clk, rst        : clock, asynchronous active-high reset
//   s_valid/s_ready : write side; s_ready is high while an entry is free
//   s_data          : write data
//   m_valid/m_ready : read side
//   m_data          : head entry
//   count           : current occupancy (0..2)
module demosaic_skid2 #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push, pop;

  assign s_ready = (cnt_q != 2'd2);
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = mem_q[rd_ptr_q];
  assign count   = cnt_q;

  always_comb begin
    push     = s_valid & s_ready;
    pop      = m_valid & m_ready;
    mem_d    = mem_q;
    if (push) mem_d[wr_ptr_q] = s_data;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) mem_q[gi] <= '0;
      else     mem_q[gi] <= mem_d[gi];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/demosaic_wsum_round_sat.sv
// Weighted-sum accumulate, round-to-nearest, shift and saturate for demosaic.
// Sums a group of up to TAPS unsigned pixel*weight products (closed by tlast or
// by reaching TAPS), rounds away SHIFT fraction bits, clamps to OUT_W bits and
// streams the pixel out through a 2-entry skid buffer.
// Optional build macro DEMOSAIC_SAT_CNT_EN enables the saturation counter;
// without it sat_cnt is tied to zero.
//   ap_clk, ap_rst          : clock, asynchronous active-high reset
//   s_prod_t{data,valid,last,ready} : product input stream
//   m_pix_t{data,user,valid,ready}  : pixel output stream, tuser = clamped
//   tap_err                 : sticky, a group reached TAPS without tlast
//   sat_cnt                 : count of clamped pixels transferred (optional)
module demosaic_wsum_round_sat
  import demosaic_pkg::*;
#(
  parameter int PROD_W = 28,
  parameter int OUT_W  = PIX_W,
  parameter int TAPS   = 4,
  parameter int SHIFT  = WEIGHT_FRAC
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] s_prod_tdata,
  input  logic              s_prod_tvalid,
  input  logic              s_prod_tlast,
  output logic              s_prod_tready,
  output logic [OUT_W-1:0]  m_pix_tdata,
  output logic              m_pix_tuser,
  output logic              m_pix_tvalid,
  input  logic              m_pix_tready,
  output logic              tap_err,
  output logic [15:0]       sat_cnt
);

  localparam int ACC_W = acc_width(PROD_W, TAPS);
  localparam int CNT_W = $clog2(TAPS + 1);
  localparam logic [CNT_W-1:0] TAPS_C  = CNT_W'(TAPS);
  localparam logic [ACC_W:0]   RND     = (ACC_W + 1)'(1) << (SHIFT - 1);
  localparam logic [ACC_W:0]   PIX_MAX = {{(ACC_W + 1 - OUT_W){1'b0}}, {OUT_W{1'b1}}};

  acc_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_new;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_new;
  logic             sum_vld_q, sum_vld_d;
  logic             err_q, err_d;
  logic             rdy_q, rdy_d;
  logic             accept;
  logic [ACC_W-1:0] prod_ext;

  assign prod_ext      = {{(ACC_W - PROD_W){1'b0}}, s_prod_tdata};
  assign accept        = s_prod_tvalid & rdy_q;
  assign s_prod_tready = rdy_q;
  assign tap_err       = err_q;

  // Stage 1: group accumulation.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    sum_vld_d = 1'b0;
    err_d     = err_q;
    acc_new   = (state_q == ST_IDLE) ? prod_ext : acc_q + prod_ext;
    cnt_new   = (state_q == ST_IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
    if (accept) begin
      if (s_prod_tlast || (cnt_new == TAPS_C)) begin
        sum_d     = acc_new;
        sum_vld_d = 1'b1;
        state_d   = ST_IDLE;
        acc_d     = '0;
        cnt_d     = '0;
        if (!s_prod_tlast) err_d = 1'b1;
      end else begin
        state_d = ST_ACCUM;
        acc_d   = acc_new;
        cnt_d   = cnt_new;
      end
    end
  end

  // Stage 2: round, shift, saturate. The extra MSB keeps the rounding add from wrapping.
  logic [ACC_W:0]   rnd_sum, rnd_shr;
  logic             sat;
  logic [OUT_W:0]   pix_word;

  always_comb begin
    rnd_sum  = {1'b0, sum_q} + RND;
    rnd_shr  = rnd_sum >> SHIFT;
    sat      = (rnd_shr > PIX_MAX);
    pix_word = {sat, sat ? {OUT_W{1'b1}} : rnd_shr[OUT_W-1:0]};
  end

  logic           skid_s_ready;
  logic [OUT_W:0] skid_m_data;
  logic [1:0]     skid_cnt;
  logic           push, pop;
  logic [2:0]     occ_next;

  demosaic_skid2 #(.W(OUT_W + 1)) u_skid (
    .clk     (ap_clk),
    .rst     (ap_rst),
    .s_valid (sum_vld_q),
    .s_ready (skid_s_ready),
    .s_data  (pix_word),
    .m_valid (m_pix_tvalid),
    .m_ready (m_pix_tready),
    .m_data  (skid_m_data),
    .count   (skid_cnt)
  );

  assign m_pix_tdata = skid_m_data[OUT_W-1:0];
  assign m_pix_tuser = skid_m_data[OUT_W];

  // A closing product accepted next cycle lands in the buffer two cycles later.
  // Ready is granted only if the buffer plus the in-flight sum leave room for it
  // even when no pixel drains in the meantime.
  always_comb begin
    push     = sum_vld_q & skid_s_ready;
    pop      = m_pix_tvalid & m_pix_tready;
    occ_next = {1'b0, skid_cnt} + {2'b0, push} - {2'b0, pop};
    rdy_d    = (occ_next + {2'b0, sum_vld_d}) <= 3'd1;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      sum_vld_q <= sum_vld_d;
      err_q     <= err_d;
      rdy_q     <= rdy_d;
    end
  end

`ifdef DEMOSAIC_SAT_CNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (pop && m_pix_tuser && (sat_cnt_q != 16'hFFFF)) sat_cnt_d = sat_cnt_q + 16'd1;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) sat_cnt_q <= '0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_cnt = sat_cnt_q;
`else
  assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_demosaic_wsum_round_sat.sv
module tb_demosaic_wsum_round_sat;

  localparam int TAPS = 4;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic [27:0] s_prod_tdata = '0;
  logic        s_prod_tvalid = 1'b0;
  logic        s_prod_tlast = 1'b0;
  logic        s_prod_tready;
  logic [7:0]  m_pix_tdata;
  logic        m_pix_tuser;
  logic        m_pix_tvalid;
  logic        m_pix_tready = 1'b1;
  logic        tap_err;
  logic [15:0] sat_cnt;

  demosaic_wsum_round_sat dut (
    .ap_clk        (ap_clk),
    .ap_rst        (ap_rst),
    .s_prod_tdata  (s_prod_tdata),
    .s_prod_tvalid (s_prod_tvalid),
    .s_prod_tlast  (s_prod_tlast),
    .s_prod_tready (s_prod_tready),
    .m_pix_tdata   (m_pix_tdata),
    .m_pix_tuser   (m_pix_tuser),
    .m_pix_tvalid  (m_pix_tvalid),
    .m_pix_tready  (m_pix_tready),
    .tap_err       (tap_err),
    .sat_cnt       (sat_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a group is a list of accepted products; its pixel is the
  // rounded real-valued sum divided by 2^20, clamped to 255.
  typedef struct packed {
    logic       user;
    logic [7:0] pix;
  } pix_t;

  function automatic pix_t ref_pix(input longint s);
    longint r;
    pix_t   p;
    r = (s + 64'd524288) / 64'd1048576;
    if (r > 255) begin p.user = 1'b1; p.pix = 8'hFF; end
    else         begin p.user = 1'b0; p.pix = 8'(r); end
    return p;
  endfunction

  longint grp_sum = 0;
  int     grp_n = 0;
  pix_t   exp_q[$];
  pix_t   hist[$];
  logic   exp_err = 1'b0;
  int     exp_sat = 0;
  int     cyc = 0;
  int     close_cyc = 0;
  int     out_cyc = 0;
  int     out_cnt = 0;
  logic   saw_nr = 1'b0;
  logic   prev_stall = 1'b0;
  pix_t   prev_out;

  always @(negedge ap_clk) begin
    cyc++;
    if (ap_rst) begin
      grp_sum = 0;
      grp_n = 0;
      exp_q.delete();
      exp_err = 1'b0;
      exp_sat = 0;
      prev_stall = 1'b0;
    end else begin
      check("tap_err", 64'(tap_err), 64'(exp_err));
      check("sat_cnt", 64'(sat_cnt), 64'(exp_sat));
      if (prev_stall) begin
        check("stall_valid", 64'(m_pix_tvalid), 64'd1);
        check("stall_data", 64'({m_pix_tuser, m_pix_tdata}), 64'(prev_out));
      end
      if (!s_prod_tready) saw_nr = 1'b1;
      if (s_prod_tvalid && s_prod_tready) begin
        grp_sum += longint'(s_prod_tdata);
        grp_n++;
        if (s_prod_tlast || grp_n == TAPS) begin
          exp_q.push_back(ref_pix(grp_sum));
          if (!s_prod_tlast) exp_err = 1'b1;
          close_cyc = cyc;
          grp_sum = 0;
          grp_n = 0;
        end
      end
      if (m_pix_tvalid && m_pix_tready) begin
        $display("pixel %0d: data=0x%02h user=%0d cycle=%0d", out_cnt, m_pix_tdata, m_pix_tuser, cyc);
        hist.push_back({m_pix_tuser, m_pix_tdata});
        out_cnt++;
        out_cyc = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel: actual=0x%02h expected=none", m_pix_tdata);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          checks--;
          check("pixel", 64'({m_pix_tuser, m_pix_tdata}), 64'(e));
        end
`ifdef DEMOSAIC_SAT_CNT_EN
        if (m_pix_tuser && exp_sat < 65535) exp_sat++;
`endif
      end
      prev_stall = m_pix_tvalid & ~m_pix_tready;
      prev_out = {m_pix_tuser, m_pix_tdata};
    end
  end

  task automatic send(input logic [27:0] d, input logic l);
    int n;
    n = 0;
    s_prod_tvalid = 1'b1;
    s_prod_tdata  = d;
    s_prod_tlast  = l;
    @(negedge ap_clk);
    while (!s_prod_tready && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $display("FAIL send_timeout: actual=stuck expected=ready");
    end
    @(posedge ap_clk);
    #1;
    s_prod_tvalid = 1'b0;
    s_prod_tlast  = 1'b0;
  endtask

  task automatic wait_out(input int target);
    int n;
    n = 0;
    while (out_cnt < target && n < 60) begin
      @(negedge ap_clk);
      n++;
    end
    checks++;
    if (out_cnt < target) begin
      errors++;
      $display("FAIL out_timeout: actual=%0d expected=%0d", out_cnt, target);
    end
  endtask

  typedef struct {
    int          n;
    logic [27:0] val;
    logic [7:0]  pix;
    logic        user;
  } vec_t;

  vec_t tbl[9];
  logic rnd_done = 1'b0;

  initial begin
    int start;
    tbl[0] = '{4, 28'h0100000, 8'h04, 1'b0};
    tbl[1] = '{1, 28'h0080000, 8'h01, 1'b0};
    tbl[2] = '{1, 28'h007FFFF, 8'h00, 1'b0};
    tbl[3] = '{4, 28'hFFFFFFF, 8'hFF, 1'b1};
    tbl[4] = '{1, 28'h0000000, 8'h00, 1'b0};
    tbl[5] = '{2, 28'h7F80000, 8'hFF, 1'b0};
    tbl[6] = '{1, 28'hFF80000, 8'hFF, 1'b1};
    tbl[7] = '{3, 28'h0100000, 8'h03, 1'b0};
    tbl[8] = '{1, 28'hFF7FFFF, 8'hFF, 1'b0};

    // Reset state
    repeat (3) @(negedge ap_clk);
    check("rst_tvalid", 64'(m_pix_tvalid), 64'd0);
    check("rst_tdata", 64'(m_pix_tdata), 64'd0);
    check("rst_tuser", 64'(m_pix_tuser), 64'd0);
    check("rst_tready", 64'(s_prod_tready), 64'd0);
    check("rst_tap_err", 64'(tap_err), 64'd0);
    check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("tready_rel0", 64'(s_prod_tready), 64'd0);
    @(negedge ap_clk);
    check("tready_rel1", 64'(s_prod_tready), 64'd1);
    @(posedge ap_clk); #1;

    // Table-driven single groups
    for (int i = 0; i < 9; i++) begin
      start = out_cnt;
      for (int j = 0; j < tbl[i].n; j++) send(tbl[i].val, j == tbl[i].n - 1);
      wait_out(start + 1);
      if (hist.size() > start) begin
        check($sformatf("tbl%0d_pix", i), 64'(hist[start].pix), 64'(tbl[i].pix));
        check($sformatf("tbl%0d_user", i), 64'(hist[start].user), 64'(tbl[i].user));
        check($sformatf("tbl%0d_latency", i), 64'(out_cyc - close_cyc), 64'd2);
      end
      @(posedge ap_clk); #1;
    end
    check("tlast_at_taps_no_err", 64'(tap_err), 64'd0);

    // Tap overflow
    start = out_cnt;
    for (int j = 0; j < 5; j++) send(28'h0100000, 1'b0);
    send(28'h0100000, 1'b1);
    wait_out(start + 2);
    if (hist.size() > start + 1) begin
      check("ovf_first", 64'(hist[start]), 64'({1'b0, 8'h04}));
      check("ovf_second", 64'(hist[start + 1]), 64'({1'b0, 8'h02}));
    end
    check("ovf_tap_err", 64'(tap_err), 64'd1);
    repeat (5) @(posedge ap_clk);
    #1;
    check("ovf_tap_err_held", 64'(tap_err), 64'd1);

    // Backpressure: back-to-back 2-tap groups with a 6-cycle output stall
    start = out_cnt;
    saw_nr = 1'b0;
    fork
      begin
        for (int g = 0; g < 6; g++) begin
          send(28'(g + 1) << 20, 1'b0);
          send(28'(g + 1) << 20, 1'b1);
        end
      end
      begin
        m_pix_tready = 1'b0;
        repeat (6) @(posedge ap_clk);
        #1;
        m_pix_tready = 1'b1;
      end
    join
    wait_out(start + 6);
    repeat (10) @(posedge ap_clk);
    #1;
    check("bp_ready_fell", 64'(saw_nr), 64'd1);
    check("bp_count", 64'(out_cnt - start), 64'd6);
    for (int g = 0; g < 6; g++)
      if (hist.size() > start + g)
        check($sformatf("bp_order%0d", g), 64'(hist[start + g]), 64'({1'b0, 8'(2 * (g + 1))}));

    // Reset mid-group
    send(28'h0100000, 1'b0);
    send(28'h0100000, 1'b0);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    check("midrst_tvalid", 64'(m_pix_tvalid), 64'd0);
    check("midrst_tready", 64'(s_prod_tready), 64'd0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    start = out_cnt;
    send(28'h0200000, 1'b1);
    wait_out(start + 1);
    repeat (10) @(posedge ap_clk);
    #1;
    check("midrst_count", 64'(out_cnt - start), 64'd1);
    if (hist.size() > start) check("midrst_pix", 64'(hist[start]), 64'({1'b0, 8'h02}));

    // Randomized traffic against the scoreboard
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          logic [27:0] v;
          int sel;
          sel = $urandom_range(0, 3);
          if (sel == 0)      v = 28'($urandom);
          else if (sel == 3) v = 28'($urandom_range(0, 32'h1FFFFF));
          else               v = 28'($urandom_range(0, 32'h3FFFFFF));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge ap_clk); #1;
          end
          send(v, $urandom_range(0, 3) == 0);
        end
        send(28'h0, 1'b1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          m_pix_tready = ($urandom_range(0, 9) < 7);
          @(posedge ap_clk); #1;
        end
        m_pix_tready = 1'b1;
      end
    join
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge ap_clk);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demosaic_wsum_round_sat.md
Name: demosaic_wsum_round_sat

Overview:
- Downstream consumer of the demosaic root multiplier, which produces unsigned 28-bit pixel × weight products.
- Weights are Q.20 fixed-point, so 0x100000 = 1.0.
- Accumulates a group of up to TAPS weighted products, one group per interpolated output sample.
- Rounds to nearest, shifts out the fraction, saturates to an 8-bit pixel.
- Emits the pixel on a valid/ready stream toward the colour-plane packer.

Parameters:
- PROD_W, 28: product input width.
- OUT_W, 8: output pixel width.
- TAPS, 4: maximum products per group (≥2).
- SHIFT, 20: fractional bits removed (≥1).

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- s_prod_tdata  in  PROD_W  unsigned product.
- s_prod_tvalid  in  1  product valid.
- s_prod_tlast  in  1  last product of the group.
- s_prod_tready  out  1  block accepts the product this cycle.
- m_pix_tdata  out  OUT_W  rounded, saturated pixel.
- m_pix_tuser  out  1  pixel was clamped.
- m_pix_tvalid  out  1  pixel valid.
- m_pix_tready  in  1  downstream accepts.
- tap_err  out  1  sticky: a group hit TAPS products without tlast.
- sat_cnt  out  16  saturation count (see Optional Feature).

Behaviour:
- Widths:
  - ACC_W = PROD_W + clog2(TAPS) (30 at defaults).
  - The rounding add is computed in ACC_W+1 bits, so it never wraps.
- Transfers:
  - An input product transfers on s_prod_tvalid & s_prod_tready.
  - An output pixel transfers on m_pix_tvalid & m_pix_tready.
- Stage 1, accumulator FSM:
  - States: IDLE, ACCUM.
  - IDLE, on a transfer: acc = product, tap_cnt = 1. If tlast is set, close the group; otherwise go to ACCUM.
  - ACCUM, on a transfer: acc += product, tap_cnt++.
  - The group closes on tlast, or when tap_cnt reaches TAPS.
  - Closing at TAPS without tlast sets tap_err. The next product then starts a new group.
  - On close: acc is handed to stage 2 as a sum-valid pulse, and the FSM returns to IDLE.
  - The new group's first product is accepted in the cycle after close at the earliest; no bubble is required.
- Stage 2, round and saturate (registered):
  - r = (acc + 2^(SHIFT-1)) >> SHIFT.
  - If r ≥ 2^OUT_W: pixel = 2^OUT_W − 1 and tuser = 1.
  - Otherwise: pixel = r[OUT_W-1:0] and tuser = 0.
- Output buffering:
  - The output register is followed by a 2-entry skid buffer, giving full throughput of one product per cycle.
- Latency: the closing product accepted in cycle N gives m_pix_tvalid in cycle N+2 when the output is not stalled.
- Backpressure:
  - s_prod_tready = 0 whenever accepting a closing product could overflow the skid buffer.
  - s_prod_tready is a registered function of the buffer occupancy, with no combinational path from m_pix_tready.
  - While m_pix_tvalid is high and the pixel has not transferred, m_pix_tdata and m_pix_tuser are stable.
- Reset (ap_rst):
  - Outputs: m_pix_tvalid = 0, m_pix_tdata = 0, m_pix_tuser = 0, s_prod_tready = 0, tap_err = 0, sat_cnt = 0.
  - Internal: FSM = IDLE, acc = 0, tap_cnt = 0, buffer empty.
  - One cycle after ap_rst deasserts, s_prod_tready = 1.
  - A group that is partially accumulated when reset hits is discarded, and no pixel is emitted for it.
- Boundaries:
  - A product of 0 is legal.
  - The maximum sum, TAPS·(2^PROD_W−1), must not wrap at any stage.
  - tlast on the TAPS-th product closes the group normally, with no tap_err.
  - Input stalls between products of a group are allowed; acc holds its value.

Optional Feature:
- Macro: DEMOSAIC_SAT_CNT_EN.
- Defined:
  - sat_cnt increments on each output transfer with tuser = 1.
  - It saturates at 0xFFFF and clears only on reset.
- Undefined:
  - The counter logic is not instantiated and sat_cnt is tied to 0.
  - The port list is identical in both builds.

Decomposition:
- Shared package demosaic_pkg:
  - Q-format constant WEIGHT_FRAC = 20.
  - Pixel width constant PIX_W = 8.
  - A function computing ACC_W.
- One sub-module: demosaic_skid2, the generic 2-entry valid/ready skid buffer, reused by other demosaic stages.

Test Plan (defaults, m_pix_tready = 1 unless stated):
- Unity sum: 4× 0x0100000, tlast on the 4th → one pixel 0x04, tuser = 0, appearing 2 cycles after the 4th transfer.
- Rounding: single 0x0080000 with tlast → 0x01. Single 0x007FFFF with tlast → 0x00.
- Saturation: 4× 0xFFFFFFF → 0xFF, tuser = 1. With DEMOSAIC_SAT_CNT_EN, sat_cnt = 1.
- Tap overflow:
  - Stimulus: 5× 0x0100000 with no tlast, then a 6th product with tlast.
  - Pixel 0x04 after the 4th product, with tap_err = 1 and held.
  - The 5th and 6th products form the next group → 0x02.
- Backpressure:
  - Stimulus: 2-tap groups streamed back-to-back with m_pix_tready = 0 for 6 cycles.
  - s_prod_tready falls once the buffer is full.
  - After release, all pixels emerge in order with no loss or duplication.
  - Output is held stable while stalled.
- Reset mid-group:
  - Stimulus: 2 products accepted, ap_rst pulsed, then 0x0200000 with tlast.
  - Only one pixel is output: 0x02.
